// File: rtl/thor2024_mul_iter_pkg.sv
// Thor2024 iterative multiplier: shared types and defaults.
package thor2024_mul_iter_pkg;

    // Default geometry of the multiply functional unit
    localparam int unsigned MUL_WID  = 64;
    localparam int unsigned MUL_BPC  = 2;
    localparam int unsigned MUL_TAGW = 5;

    // Multiplier sequencing states
    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_FIX,
        MUL_DONE
    } mul_state_t;

    // Operation flags latched at accept; the decoder maps
    // FN_MULU/OP_MULUI -> hi=0,sgn=0 and FN_MULUH -> hi=1,sgn=0
    typedef struct packed {
        logic hi;
        logic sgn;
    } mul_op_t;

    // Number of RUN iterations for a given width and bits per cycle
    function automatic int unsigned mul_iters(input int unsigned wid, input int unsigned bpc);
        return wid / bpc;
    endfunction

endpackage

// File: rtl/thor2024_mul_iter_step.sv
// One radix-2^BPC multiply step: add mcand * digit to the accumulator and
// shift the {acc, mplier} pair right by BPC bits.
module thor2024_mul_iter_step
    import thor2024_mul_iter_pkg::*;
#(
    parameter int unsigned WID = MUL_WID,
    parameter int unsigned BPC = MUL_BPC
) (
    input  logic [WID-1:0] mcand_i,
    input  logic [WID-1:0] acc_i,
    input  logic [WID-1:0] mplier_i,
    output logic [WID-1:0] acc_o,
    output logic [WID-1:0] mplier_o
);

    logic [WID+BPC-1:0] mcand_x;
    logic [WID+BPC-1:0] digit_x;
    logic [WID+BPC-1:0] pp;
    logic [WID+BPC-1:0] sum;

    // Partial product and carry-keeping add; the sum needs WID+BPC bits but
    // after the shift the accumulator always fits back into WID bits
    always_comb begin
        mcand_x  = {{BPC{1'b0}}, mcand_i};
        digit_x  = {{WID{1'b0}}, mplier_i[BPC-1:0]};
        pp       = mcand_x * digit_x;
        sum      = {{BPC{1'b0}}, acc_i} + pp;
        acc_o    = sum[WID+BPC-1:BPC];
        mplier_o = {sum[BPC-1:0], mplier_i[WID-1:BPC]};
    end

endmodule

// File: rtl/thor2024_mul_iter.sv
// Thor2024 iterative integer multiplier functional unit.
// Fixed latency: accept, WID/BPC RUN cycles, one FIX cycle, then DONE.
module thor2024_mul_iter
    import thor2024_mul_iter_pkg::*;
#(
    parameter int unsigned WID  = MUL_WID,
    parameter int unsigned BPC  = MUL_BPC,
    parameter int unsigned TAGW = MUL_TAGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [WID-1:0]  req_a,
    input  logic [WID-1:0]  req_b,
    input  logic            req_hi,
    input  logic            req_sgn,
    input  logic [TAGW-1:0] req_tag,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [WID-1:0]  res,
    output logic [TAGW-1:0] res_tag,
    output logic            busy
);

    localparam int unsigned ITERS = mul_iters(WID, BPC);
    localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);

    mul_state_t      state;
    logic [WID-1:0]  mcand;
    logic [WID-1:0]  acc;
    logic [WID-1:0]  mplier;
    logic [CW-1:0]   cnt;
    logic            neg;
    mul_op_t         op;
    logic [TAGW-1:0] tag;

    logic            accept;
    logic [WID-1:0]  a_mag;
    logic [WID-1:0]  b_mag;
    logic [WID-1:0]  acc_nxt;
    logic [WID-1:0]  mplier_nxt;
    logic [2*WID-1:0] prod_raw;
    logic [2*WID-1:0] prod_fix;

    // Operand magnitudes; -2^(WID-1) negates to itself, which read as unsigned
    // is the correct magnitude 2^(WID-1)
    always_comb begin
        accept = req_valid && req_ready && !flush;
        a_mag  = (req_sgn && req_a[WID-1]) ? -req_a : req_a;
        b_mag  = (req_sgn && req_b[WID-1]) ? -req_b : req_b;
    end

    thor2024_mul_iter_step #(
        .WID (WID),
        .BPC (BPC)
    ) u_step (
        .mcand_i  (mcand),
        .acc_i    (acc),
        .mplier_i (mplier),
        .acc_o    (acc_nxt),
        .mplier_o (mplier_nxt)
    );

    // Full product and its sign correction
    always_comb begin
        prod_raw = {acc, mplier};
        prod_fix = neg ? -prod_raw : prod_raw;
    end

    // Sequencer and datapath registers; flush overrides every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MUL_IDLE;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            res       <= '0;
            res_tag   <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            op        <= '0;
            tag       <= '0;
        end else if (flush) begin
            state     <= MUL_IDLE;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                MUL_IDLE: begin
                    if (accept) begin
                        mcand     <= a_mag;
                        mplier    <= b_mag;
                        acc       <= '0;
                        neg       <= req_sgn & (req_a[WID-1] ^ req_b[WID-1]);
                        op.hi     <= req_hi;
                        op.sgn    <= req_sgn;
                        tag       <= req_tag;
                        cnt       <= CNT_INIT;
                        state     <= MUL_RUN;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= MUL_FIX;
                    end
                end
                MUL_FIX: begin
                    res       <= op.hi ? prod_fix[2*WID-1:WID] : prod_fix[WID-1:0];
                    res_tag   <= tag;
                    res_valid <= 1'b1;
                    state     <= MUL_DONE;
                end
                MUL_DONE: begin
                    // res/res_tag hold until writeback takes them
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= MUL_IDLE;
                    end
                end
                default: begin
                    state     <= MUL_IDLE;
                    req_ready <= 1'b1;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thor2024_mul_iter.sv
// Self-checking bench for thor2024_mul_iter with a result scoreboard.
module tb_thor2024_mul_iter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_hi;
    logic        req_sgn;
    logic [4:0]  req_tag;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res;
    logic [4:0]  res_tag;
    logic        busy;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  t;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    thor2024_mul_iter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_hi    (req_hi),
        .req_sgn   (req_sgn),
        .req_tag   (req_tag),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full 128-bit product from sign- or zero-extended operands
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic hi, input logic sgn);
        logic [127:0] ax, bx, p;
        ax = sgn ? {{64{a[63]}}, a} : {64'd0, a};
        bx = sgn ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ax * bx;
        return hi ? p[127:64] : p[63:0];
    endfunction

    // Present one request in IDLE; returns just after the accept edge
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic hi,
                         input logic sgn, input logic [4:0] tag, input bit push,
                         input logic [63:0] exp_r);
        exp_t e;
        @(negedge clk);
        req_a = a; req_b = b; req_hi = hi; req_sgn = sgn; req_tag = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (push) begin
            e.r = exp_r; e.t = tag;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for a result, optionally stall, consume it, pop expected
    task automatic collect(input int hold, output logic [63:0] r, output logic [4:0] t,
                           output logic [63:0] er, output logic [4:0] et,
                           output int lat, output bit to);
        exp_t e;
        lat = 1; to = 1'b0; r = 'x; t = 'x; er = '0; et = '0;
        @(negedge clk);
        while (!res_valid && lat < 200) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (!res_valid) begin
            to = 1'b1;
            return;
        end
        repeat (hold) @(negedge clk);
        r = res; t = res_tag;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front(); er = e.r; et = e.t;
        end else begin
            to = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res !== 64'd0 || res_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset: rr=%b rv=%b busy=%b res=%h tag=%h want 1 0 0 0 0",
                     req_ready, res_valid, busy, res, res_tag);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_directed(input string name, input logic [63:0] a, input logic [63:0] b,
                                input logic hi, input logic sgn, input logic [4:0] tag,
                                input logic [63:0] want);
        logic [63:0] r, er;
        logic [4:0]  t, et;
        int lat;
        bit to;
        issue(a, b, hi, sgn, tag, 1'b1, want);
        collect(0, r, t, er, et, lat, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL %s timeout: no result", name);
        end else begin
            checks += 2;
            if (r !== er) begin
                errors++; $display("FAIL %s res: got %h want %h", name, r, er);
            end
            if (t !== et) begin
                errors++; $display("FAIL %s tag: got %0d want %0d", name, t, et);
            end
            if (lat !== 34) begin
                errors++; $display("FAIL %s latency: got %0d want 34", name, lat);
            end
        end
    endtask

    task automatic test_unsigned();
        run_directed("unsigned_lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 5'd1,
                     64'hFFFF_FFFF_FFFF_FFFE);
        run_directed("unsigned_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 5'd2, 64'd1);
        run_directed("zero_operand", 64'd0, 64'hDEAD_BEEF_0000_1234, 1'b0, 1'b0, 5'd3, 64'd0);
    endtask

    task automatic test_signed();
        run_directed("signed_lo", -64'sd3, 64'd7, 1'b0, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFEB);
        run_directed("signed_hi", -64'sd3, 64'd7, 1'b1, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_corner();
        run_directed("corner_hi", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     1'b1, 1'b1, 5'd6, 64'h4000_0000_0000_0000);
        run_directed("corner_lo", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     1'b0, 1'b1, 5'd7, 64'd0);
    endtask

    task automatic test_backpressure();
        logic [63:0] cap_r;
        logic [4:0]  cap_t;
        exp_t e;
        int n;
        bit bad;
        issue(64'h1234, 64'h10, 1'b0, 1'b0, 5'd9, 1'b1, 64'h12340);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (!res_valid) begin
            errors++; $display("FAIL bp_valid: got 0 want 1");
        end
        cap_r = res; cap_t = res_tag;
        e = sb.pop_front();
        checks += 2;
        if (cap_r !== e.r) begin
            errors++; $display("FAIL bp_res: got %h want %h", cap_r, e.r);
        end
        if (cap_t !== e.t) begin
            errors++; $display("FAIL bp_tag: got %0d want %0d", cap_t, e.t);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res !== cap_r || res_tag !== cap_t ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: rv=%b res=%h tag=%0d rr=%b want 1 %h %0d 0",
                         i, res_valid, res, res_tag, req_ready, cap_r, cap_t);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b rr=%b rv=%b want 0 1 0", busy, req_ready, res_valid);
        end
    endtask

    task automatic test_flush();
        logic [63:0] r, er;
        logic [4:0]  t, et;
        int lat;
        bit to, seen;
        // Request together with flush in IDLE is dropped
        @(negedge clk);
        req_a = 64'd1; req_b = 64'd1; req_hi = 1'b0; req_sgn = 1'b0; req_tag = 5'd12;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_idle_accept: busy=%b rr=%b want 0 1", busy, req_ready);
        end
        // Kill an op at iteration 5
        issue(64'd5, 64'd9, 1'b0, 1'b0, 5'd8, 1'b0, 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: busy=%b rr=%b rv=%b want 0 1 0", busy, req_ready, res_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL flush_no_result: res_valid seen=1 want 0");
        end
        issue(64'd5, 64'd9, 1'b0, 1'b0, 5'd3, 1'b1, 64'd45);
        collect(0, r, t, er, et, lat, to);
        checks++;
        if (to || r !== er || t !== et) begin
            errors++;
            $display("FAIL flush_next_op: to=%b res=%0d tag=%0d want res=%0d tag=%0d",
                     to, r, t, er, et);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        issue(64'd77, 64'd99, 1'b0, 1'b0, 5'd10, 1'b0, 64'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy=%b rv=%b rr=%b want 0 0 1", busy, res_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL async_reset_no_result: res_valid seen=1 want 0");
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, er;
        logic [4:0]  t, et, tag;
        logic        hi, sgn;
        int lat, sel;
        bit to;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) a = 64'h8000_0000_0000_0000;
            if (sel == 1) b = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 2) b = {32'd0, b[31:0]};
            hi  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            tag = 5'($urandom_range(0, 31));
            issue(a, b, hi, sgn, tag, 1'b1, model(a, b, hi, sgn));
            collect($urandom_range(0, 3), r, t, er, et, lat, to);
            checks++;
            if (to || r !== er || t !== et || lat !== 34) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h hi=%b sgn=%b: res=%h tag=%0d lat=%0d to=%b want %h %0d 34",
                         i, a, b, hi, sgn, r, t, lat, to, er, et);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_hi = 1'b0;
        req_sgn = 1'b0; req_tag = '0; flush = 1'b0; res_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corner();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
